// File: rtl/loba_mult_pipe.sv
// Pipelined leading-one-bit-based approximate unsigned multiplier with
// valid/ready backpressure, tag passthrough and a lossless indicator.
module loba_mult_pipe #(
    parameter int W     = 16,
    parameter int K     = 4,
    parameter int TERMS = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_lossless
);
    localparam int SW = $clog2(W);
    localparam int PW = 2 * W;

    function automatic logic [SW-1:0] lead_one(input logic [W-1:0] x);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // A zero input yields index 0, which keeps the shift at 0 and the segment at 0.
    function automatic void split_seg(input  logic [W-1:0]  x,
                                      output logic [K-1:0]  seg,
                                      output logic [SW-1:0] sh,
                                      output logic [W-1:0]  rem);
        logic [SW-1:0] n;
        n   = lead_one(x);
        sh  = (n >= SW'(K - 1)) ? n - SW'(K - 1) : '0;
        seg = K'(x >> sh);
        rem = x - (W'(seg) << sh);
    endfunction

    function automatic logic [PW-1:0] term(input logic [K-1:0]  x,
                                           input logic [K-1:0]  y,
                                           input logic [SW-1:0] kx,
                                           input logic [SW-1:0] ky);
        logic [PW-1:0] prod;
        prod = PW'(x) * PW'(y);
        return prod << ({1'b0, kx} + {1'b0, ky});
    endfunction

    logic adv;
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    logic [K-1:0]  ah_c, al_c, bh_c, bl_c;
    logic [SW-1:0] akh_c, akl_c, bkh_c, bkl_c;
    logic [W-1:0]  ra_c, ra2_c, rb_c, rb2_c;

    always_comb begin
        split_seg(in_a, ah_c, akh_c, ra_c);
        split_seg(ra_c, al_c, akl_c, ra2_c);
        split_seg(in_b, bh_c, bkh_c, rb_c);
        split_seg(rb_c, bl_c, bkl_c, rb2_c);
    end

    logic             v1, mode1;
    logic [TAG_W-1:0] tag1;
    logic [K-1:0]     ah1, al1, bh1, bl1;
    logic [SW-1:0]    akh1, akl1, bkh1, bkl1;
    logic             az1, bz1, raz1, rbz1, ra2z1, rb2z1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; mode1 <= 1'b0; tag1 <= '0;
            ah1 <= '0; al1 <= '0; bh1 <= '0; bl1 <= '0;
            akh1 <= '0; akl1 <= '0; bkh1 <= '0; bkl1 <= '0;
            az1 <= 1'b0; bz1 <= 1'b0; raz1 <= 1'b0; rbz1 <= 1'b0;
            ra2z1 <= 1'b0; rb2z1 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid; mode1 <= in_mode; tag1 <= in_tag;
            ah1 <= ah_c; al1 <= al_c; bh1 <= bh_c; bl1 <= bl_c;
            akh1 <= akh_c; akl1 <= akl_c; bkh1 <= bkh_c; bkl1 <= bkl_c;
            az1 <= (in_a == '0); bz1 <= (in_b == '0);
            raz1 <= (ra_c == '0); rbz1 <= (rb_c == '0);
            ra2z1 <= (ra2_c == '0); rb2z1 <= (rb2_c == '0);
        end
    end

    logic any_zero, loss_c;
    always_comb begin
        any_zero = az1 || bz1;
        if (mode1)
            loss_c = (ra2z1 && rb2z1 && ((TERMS == 4) || al1 == '0 || bl1 == '0)) || any_zero;
        else
            loss_c = (raz1 && rbz1) || any_zero;
    end

    logic             v2, mode2, loss2;
    logic [TAG_W-1:0] tag2;
    logic [PW-1:0]    hh2, hl2, lh2, ll2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0; mode2 <= 1'b0; loss2 <= 1'b0; tag2 <= '0;
            hh2 <= '0; hl2 <= '0; lh2 <= '0; ll2 <= '0;
        end else if (adv) begin
            v2 <= v1; mode2 <= mode1; loss2 <= loss_c; tag2 <= tag1;
            hh2 <= term(ah1, bh1, akh1, bkh1);
            hl2 <= term(ah1, bl1, akh1, bkl1);
            lh2 <= term(al1, bh1, akl1, bkh1);
            ll2 <= term(al1, bl1, akl1, bkl1);
        end
    end

    // Truncated terms never exceed the exact product, so the sum cannot overflow.
    logic [PW-1:0] sum_c;
    always_comb begin
        sum_c = hh2;
        if (mode2) begin
            sum_c = hh2 + hl2 + lh2;
            if (TERMS == 4) sum_c = sum_c + ll2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; out_p <= '0; out_tag <= '0; out_lossless <= 1'b0;
        end else if (adv) begin
            out_valid <= v2; out_p <= sum_c; out_tag <= tag2; out_lossless <= loss2;
        end
    end
endmodule

// File: tb/tb_loba_mult_pipe.sv
// Self-checking bench: two instances (3-term and 4-term) against a behavioural
// scoreboard, plus directed literal checks for latency, backpressure and reset.
module tb_loba_mult_pipe;
    localparam int W = 16;
    localparam int K = 4;

    typedef struct {
        logic [31:0] p3;
        logic [31:0] p4;
        logic [3:0]  tag;
        logic        l3;
        logic        l4;
    } exp_t;

    logic clk, rst_n, in_valid, in_mode, out_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic in_ready3, out_valid3, out_lossless3;
    logic in_ready4, out_valid4, out_lossless4;
    logic [31:0] out_p3, out_p4;
    logic [3:0]  out_tag3, out_tag4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [3:0] log_tag[$];
    int log_cyc[$];

    loba_mult_pipe #(.W(16), .K(4), .TERMS(3), .TAG_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid3), .out_ready(out_ready), .out_p(out_p3),
        .out_tag(out_tag3), .out_lossless(out_lossless3));

    loba_mult_pipe #(.W(16), .K(4), .TERMS(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready), .out_p(out_p4),
        .out_tag(out_tag4), .out_lossless(out_lossless4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void splitx(input longint x, output longint h,
                                   output longint kh, output longint r);
        longint n = -1;
        for (int i = 0; i < 32; i++) if (((x >> i) & 1) == 1) n = i;
        if (x == 0) begin
            h = 0; kh = 0; r = 0;
        end else begin
            kh = (n - K + 1 > 0) ? n - K + 1 : 0;
            h  = x >> kh;
            r  = x - (h << kh);
        end
    endfunction

    function automatic exp_t model(input longint a, input longint b,
                                   input logic mode, input logic [3:0] tag);
        exp_t m;
        longint ah, akh, ra, al, akl, ra2, bh, bkh, rb, bl, bkl, rb2;
        longint hh, hl, lh, ll;
        logic l0, anyz;
        splitx(a, ah, akh, ra);  splitx(ra, al, akl, ra2);
        splitx(b, bh, bkh, rb);  splitx(rb, bl, bkl, rb2);
        hh = (ah * bh) << (akh + bkh);
        hl = (ah * bl) << (akh + bkl);
        lh = (al * bh) << (akl + bkh);
        ll = (al * bl) << (akl + bkl);
        anyz = (a == 0) || (b == 0);
        l0 = (ra == 0 && rb == 0) || anyz;
        m.tag = tag;
        m.p3 = 32'(mode ? hh + hl + lh : hh);
        m.p4 = 32'(mode ? hh + hl + lh + ll : hh);
        m.l3 = mode ? ((ra2 == 0 && rb2 == 0 && (al == 0 || bl == 0)) || anyz) : l0;
        m.l4 = mode ? ((ra2 == 0 && rb2 == 0) || anyz) : l0;
        return m;
    endfunction

    // Scoreboard: the head of the queue must be on the outputs whenever they are valid.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            checkOutput("in_ready", {63'd0, in_ready3}, {63'd0, out_ready || !out_valid3});
            checkOutput("valid_t4", {63'd0, out_valid4}, {63'd0, out_valid3});
            if (out_valid3) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got tag %0h expected no result", out_tag3);
                end else begin
                    e = exp_q[0];
                    checkOutput("p_t3", 64'(out_p3), 64'(e.p3));
                    checkOutput("tag_t3", 64'(out_tag3), 64'(e.tag));
                    checkOutput("loss_t3", 64'(out_lossless3), 64'(e.l3));
                    checkOutput("p_t4", 64'(out_p4), 64'(e.p4));
                    checkOutput("tag_t4", 64'(out_tag4), 64'(e.tag));
                    checkOutput("loss_t4", 64'(out_lossless4), 64'(e.l4));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        log_tag.push_back(out_tag3);
                        log_cyc.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready3)
                exp_q.push_back(model(longint'(in_a), longint'(in_b), in_mode, in_tag));
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic mode, input logic [3:0] tag);
        bit done = 0;
        in_a = a; in_b = b; in_mode = mode; in_tag = tag; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready3;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic directedOp(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic mode, input logic [31:0] exp_p,
                              input logic exp_l, input logic [31:0] exp_p4);
        int lat = 1;
        applyStimulus(a, b, mode, 4'h5);
        while (!out_valid3 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'd3);
        checkOutput({name, "_p"}, 64'(out_p3), 64'(exp_p));
        checkOutput({name, "_lossless"}, 64'(out_lossless3), 64'(exp_l));
        checkOutput({name, "_p4"}, 64'(out_p4), 64'(exp_p4));
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !out_valid3) break;
            @(posedge clk); #1;
        end
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [15:0] randOperand();
        int w = $urandom_range(0, 16);
        logic [31:0] mask = (32'd1 << w) - 32'd1;
        return 16'($urandom & mask);
    endfunction

    initial begin
        exp_t m;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;

        m = model(64'hFFFF, 64'hFFFF, 1'b1, 4'h0);
        checkOutput("model_ffff_m1", 64'(m.p3), 64'hFD200000);
        checkOutput("model_ffff_m1_t4", 64'(m.p4), 64'hFE010000);
        m = model(64'h0180, 64'h0011, 1'b1, 4'h0);
        checkOutput("model_0180", 64'(m.p3), 64'h1980);
        checkOutput("model_0180_loss", 64'(m.l3), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(out_valid3), 64'd0);
        checkOutput("reset_p", 64'(out_p3), 64'd0);
        checkOutput("reset_tag", 64'(out_tag3), 64'd0);
        checkOutput("reset_loss", 64'(out_lossless3), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready3), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directedOp("small", 16'h0005, 16'h0003, 1'b1, 32'h0000000F, 1'b1, 32'h0000000F);
        directedOp("ffff_m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFD200000, 1'b0, 32'hFE010000);
        directedOp("ffff_m0", 16'hFFFF, 16'hFFFF, 1'b0, 32'hE1000000, 1'b0, 32'hE1000000);
        directedOp("exact", 16'h0180, 16'h0011, 1'b1, 32'h00001980, 1'b1, 32'h00001980);
        directedOp("zero", 16'h0000, 16'hBEEF, 1'b1, 32'h00000000, 1'b1, 32'h00000000);
        waitDrain(20);

        log_tag.delete(); log_cyc.delete();
        for (int i = 0; i < 8; i++)
            applyStimulus(randOperand(), randOperand(), 1'($urandom), 4'(i));
        waitDrain(20);
        checkOutput("stream_count", 64'(log_tag.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_tag.size(); i++) begin
            checkOutput("stream_tag", 64'(log_tag[i]), 64'(i));
            checkOutput("stream_cycle", 64'(log_cyc[i] - log_cyc[0]), 64'(i));
        end

        log_tag.delete(); log_cyc.delete();
        applyStimulus(16'h1234, 16'h0F0F, 1'b1, 4'h8);
        for (int i = 0; i < 10 && !out_valid3; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(16'hABCD, 16'h0077, 1'b1, 4'h9);
        applyStimulus(16'h00FF, 16'h8001, 1'b0, 4'hA);
        applyStimulus(16'h4321, 16'h1111, 1'b1, 4'hB);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("stall_valid", 64'(out_valid3), 64'd1);
        checkOutput("stall_in_ready", 64'(in_ready3), 64'd0);
        checkOutput("stall_tag", 64'(out_tag3), 64'h9);
        out_ready = 1'b1;
        waitDrain(20);
        checkOutput("stall_count", 64'(log_tag.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_tag.size(); i++)
            checkOutput("stall_order", 64'(log_tag[i]), 64'(8 + i));

        applyStimulus(16'h0101, 16'h0202, 1'b1, 4'hC);
        applyStimulus(16'h0303, 16'h0404, 1'b1, 4'hD);
        applyStimulus(16'h0505, 16'h0606, 1'b1, 4'hE);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(out_valid3), 64'd0);
        checkOutput("midreset_valid4", 64'(out_valid4), 64'd0);
        checkOutput("midreset_p", 64'(out_p3), 64'd0);
        log_tag.delete(); log_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        checkOutput("no_stale", 64'(log_tag.size()), 64'd0);
        checkOutput("no_stale_valid", 64'(out_valid3), 64'd0);

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = randOperand();
            in_b      = randOperand();
            in_mode   = 1'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitDrain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
